// File: rtl/divider_taint_track_bitwise.sv
// -----------------------------------------------------------------------------
// divider_taint_track_bitwise
//
// Constant-time restoring unsigned divider with bitwise taint tracking.
// Every division takes exactly WIDTH+2 cycles from an accepted start to the
// done pulse, whatever the operand values, because the subtract and the
// restore paths are both evaluated on every iteration.
//
// Ports
//   clk             sole clock, rising edge
//   rst             asynchronous, active-low reset
//   start/start_t   request pulse and its taint (sampled only in IDLE)
//   dividend(_t)    unsigned dividend and its bitwise taint
//   divisor(_t)     unsigned divisor and its bitwise taint
//   quotient(_t)    registered quotient and its taint
//   remainder(_t)   registered remainder and its taint
//   quotientDone    one-cycle completion pulse
//   quotientDone_t  taint of quotientDone (set when the accepted start was tainted)
//   state_dbg       current FSM state, for observation only
//
// Handshake: start is a request pulse. It is accepted only on a rising edge
// where the FSM is in IDLE; at any other time it is ignored together with its
// taint. There is no back-pressure. quotientDone is high for exactly one cycle
// and the results are valid in that cycle; the result registers then hold
// their values until the next completion or reset.
// -----------------------------------------------------------------------------
module divider_taint_track_bitwise #(
  parameter int WIDTH = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] dividend_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] divisor_t,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] quotient_t,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] remainder_t,
  output logic             quotientDone,
  output logic             quotientDone_t,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q, dvd_t_q;   // dividend, shifted left as bits are consumed
  logic [WIDTH-1:0] dsr_q, dsr_t_q;   // divisor and its taint
  logic [WIDTH-1:0] r_q, r_t_q;       // partial remainder
  logic [WIDTH-1:0] q_q, q_t_q;       // partial quotient
  logic             taint_q;          // control (state) taint of the current request
  logic [WIDTH-1:0] quotient_q, quotient_t_q;
  logic [WIDTH-1:0] remainder_q, remainder_t_q;

  // ---------------------------------------------------------------------------
  // One restoring step. R's MSB is never set before the last step (R is always
  // below 2^(steps taken)), so dropping it when forming S loses nothing.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] s, s_t;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] sub_t;
  logic             q_t;
  logic [WIDTH-1:0] r_t_next;
  logic             acc;

  always_comb begin
    s      = {r_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    s_t    = {r_t_q[WIDTH-2:0], dvd_t_q[WIDTH-1]};
    diff   = {1'b0, s} - {1'b0, dsr_q};
    q_bit  = ~diff[WIDTH];
    r_next = q_bit ? diff[WIDTH-1:0] : s;

    // Borrow runs from LSB upward, so bit k of the difference can depend on
    // any tainted bit at or below k: prefix OR of both operand taints.
    acc   = 1'b0;
    sub_t = '0;
    for (int k = 0; k < WIDTH; k++) begin
      acc      = acc | s_t[k] | dsr_t_q[k];
      sub_t[k] = acc;
    end
    // The comparison outcome depends on every bit of both operands.
    q_t = acc;

    if (q_t) begin
      r_t_next = '1;
    end else begin
      r_t_next = q_bit ? sub_t : s_t;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = ITER;
      ITER:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q         <= '0;
      dvd_q         <= '0;
      dvd_t_q       <= '0;
      dsr_q         <= '0;
      dsr_t_q       <= '0;
      r_q           <= '0;
      r_t_q         <= '0;
      q_q           <= '0;
      q_t_q         <= '0;
      taint_q       <= 1'b0;
      quotient_q    <= '0;
      quotient_t_q  <= '0;
      remainder_q   <= '0;
      remainder_t_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Accepting an untainted start clears the control taint.
          if (start) taint_q <= start_t;
        end
        LOAD: begin
          dvd_q   <= dividend;
          dvd_t_q <= dividend_t;
          dsr_q   <= divisor;
          dsr_t_q <= divisor_t;
          r_q     <= '0;
          r_t_q   <= '0;
          q_q     <= '0;
          q_t_q   <= '0;
          cnt_q   <= CW'(WIDTH - 1);
        end
        ITER: begin
          dvd_q   <= {dvd_q[WIDTH-2:0], 1'b0};
          dvd_t_q <= {dvd_t_q[WIDTH-2:0], 1'b0};
          r_q     <= r_next;
          r_t_q   <= r_t_next;
          q_q     <= {q_q[WIDTH-2:0], q_bit};
          q_t_q   <= {q_t_q[WIDTH-2:0], q_t};
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            // Last step: results land in the output registers as DONE begins.
            quotient_q    <= {q_q[WIDTH-2:0], q_bit};
            remainder_q   <= r_next;
            quotient_t_q  <= taint_q ? '1 : {q_t_q[WIDTH-2:0], q_t};
            remainder_t_q <= taint_q ? '1 : r_t_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient       = quotient_q;
  assign quotient_t     = quotient_t_q;
  assign remainder      = remainder_q;
  assign remainder_t    = remainder_t_q;
  assign quotientDone   = (state_q == DONE);
  assign quotientDone_t = (state_q == DONE) & taint_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_divider_taint_track_bitwise.sv
module tb_divider_taint_track_bitwise;

  localparam int W  = 8;
  localparam int EW = 4 * W + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start, start_t;
  logic [W-1:0] dividend, dividend_t, divisor, divisor_t;
  logic [W-1:0] quotient, quotient_t, remainder, remainder_t;
  logic         quotientDone, quotientDone_t;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  divider_taint_track_bitwise #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_t        (start_t),
    .dividend       (dividend),
    .dividend_t     (dividend_t),
    .divisor        (divisor),
    .divisor_t      (divisor_t),
    .quotient       (quotient),
    .quotient_t     (quotient_t),
    .remainder      (remainder),
    .remainder_t    (remainder_t),
    .quotientDone   (quotientDone),
    .quotientDone_t (quotientDone_t),
    .state_dbg      (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer division plus taint reasoning at the level of
  // "which quotient bits can be influenced by a secret".
  //  - tainted start or any tainted divisor bit: everything tainted.
  //  - otherwise quotient bit b is tainted iff some dividend bit at or above b
  //    is tainted (from the first tainted bit onward every step is tainted),
  //    and the remainder is fully tainted iff any dividend bit is tainted.
  function automatic logic [EW-1:0] model(input logic [W-1:0] dd, input logic [W-1:0] dv,
                                          input logic [W-1:0] ddt, input logic [W-1:0] dvt,
                                          input logic st);
    logic [W-1:0] q, r, qt, rt;
    if (dv == 0) begin
      q = '1;
      r = dd;
    end else begin
      q = dd / dv;
      r = dd % dv;
    end
    if (st || dvt != 0) begin
      qt = '1;
      rt = '1;
    end else begin
      rt = (ddt != 0) ? '1 : '0;
      for (int b = 0; b < W; b++) qt[b] = ((ddt >> b) != 0);
    end
    return {q, r, qt, rt, st};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver / monitor. Called at a falling edge; drives start, then watches
  // WIDTH+3 cycles. Returns at the falling edge of the cycle after DONE, so a
  // following call restarts at the earliest legal point.
  // stray_k >= 1 pulses an extra (tainted) start during the operation.
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                        input logic [W-1:0] ddt, input logic [W-1:0] dvt,
                        input logic st, input int stray_k);
    int pulses;
    int pos;
    logic [EW-1:0] e;
    logic [W-1:0] eq, er, eqt, ert;
    logic edt;
    pulses     = 0;
    pos        = -1;
    eq = '0; er = '0; eqt = '0; ert = '0; edt = 1'b0;
    dividend   = dd;
    divisor    = dv;
    dividend_t = ddt;
    divisor_t  = dvt;
    start      = 1'b1;
    start_t    = st;
    exp_q.push_back(model(dd, dv, ddt, dvt, st));
    @(posedge clk);
    for (int k = 0; k <= W + 2; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start   = 1'b0;
        start_t = 1'b0;
      end
      if (k == 1) begin
        // Operands were captured in LOAD; later changes must not matter.
        dividend   = W'($urandom);
        divisor    = W'($urandom);
        dividend_t = W'($urandom);
        divisor_t  = W'($urandom);
      end
      if (stray_k >= 0 && k == stray_k + 1) begin
        start   = 1'b0;
        start_t = 1'b0;
      end
      if (k == stray_k) begin
        start    = 1'b1;
        start_t  = 1'b1;
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      if (quotientDone === 1'b1) begin
        pulses++;
        pos = k;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          {eq, er, eqt, ert, edt} = e;
          check_eq("quotient",       quotient,       eq);
          check_eq("remainder",      remainder,      er);
          check_eq("quotient_t",     quotient_t,     eqt);
          check_eq("remainder_t",    remainder_t,    ert);
          check_eq("quotientDone_t", quotientDone_t, edt);
        end else begin
          check_eq("done_unexpected", 1, 0);
        end
      end
      if (k == W + 2 && pos >= 0) begin
        check_eq("hold_quotient",  quotient,  eq);
        check_eq("hold_remainder", remainder, er);
      end
    end
    check_eq("done_pulses", pulses, 1);
    check_eq("done_cycle",  pos,    W + 1);
  endtask

  // Reset asserted mid-operation: outputs clear at once, no done pulse.
  task automatic reset_mid_op();
    dividend   = 8'd100;
    divisor    = 8'd7;
    dividend_t = '0;
    divisor_t  = '0;
    start      = 1'b1;
    start_t    = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start   = 1'b0;
        start_t = 1'b0;
      end
      check_eq("rst_pre_done", quotientDone, 0);
    end
    rst = 1'b0;
    #1;
    check_eq("rst_quotient",       quotient,       0);
    check_eq("rst_remainder",      remainder,      0);
    check_eq("rst_quotient_t",     quotient_t,     0);
    check_eq("rst_remainder_t",    remainder_t,    0);
    check_eq("rst_done",           quotientDone,   0);
    check_eq("rst_done_t",         quotientDone_t, 0);
    @(negedge clk);
    check_eq("rst_hold_done", quotientDone, 0);
    rst = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      check_eq("rst_no_done", quotientDone, 0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    start_t    = 1'b0;
    dividend   = '0;
    divisor    = '0;
    dividend_t = '0;
    divisor_t  = '0;
    #1;
    check_eq("reset_quotient",    quotient,       0);
    check_eq("reset_remainder",   remainder,      0);
    check_eq("reset_quotient_t",  quotient_t,     0);
    check_eq("reset_remainder_t", remainder_t,    0);
    check_eq("reset_done",        quotientDone,   0);
    check_eq("reset_done_t",      quotientDone_t, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op(8'd100, 8'd7, 8'h00, 8'h00, 1'b0, -1);   // 14 r 2
    run_op(8'h5A,  8'd0, 8'h00, 8'h00, 1'b0, -1);   // divide by zero
    run_op(8'd100, 8'd7, 8'h01, 8'h00, 1'b0, -1);   // LSB dividend taint
    run_op(8'd100, 8'd7, 8'h00, 8'h00, 1'b1, -1);   // tainted start
    run_op(8'd9,   8'd3, 8'h00, 8'h00, 1'b0, -1);   // taint kill, back-to-back
    run_op(8'd100, 8'd7, 8'h00, 8'h00, 1'b0, 3);    // stray start mid-operation
    run_op(8'd200, 8'd13, 8'h00, 8'h04, 1'b0, W + 1); // stray start in DONE, divisor taint
    run_op(8'd255, 8'd255, 8'h20, 8'h00, 1'b0, -1);

    reset_mid_op();
    run_op(8'd100, 8'd7, 8'h00, 8'h00, 1'b0, -1);   // first start after release

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] dd, dv, ddt, dvt;
      logic st;
      int sk;
      dd  = W'($urandom_range(0, 255));
      dv  = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom_range(1, 255));
      ddt = ($urandom_range(0, 1) == 0) ? W'(0) : W'($urandom_range(0, 255));
      dvt = ($urandom_range(0, 3) == 0) ? W'(1 << $urandom_range(0, W - 1)) : W'(0);
      st  = ($urandom_range(0, 3) == 0);
      sk  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, W + 1) : -1;
      run_op(dd, dv, ddt, dvt, st, sk);
    end

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
